mips_mc_control_fsm: RTL and testbench

- Main control state machine of the 32-bit multi-cycle MIPS processor.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Drives all datapath mux selects and write enables.
- Produces the combined PC write enable consumed directly by the program counter register.
- Adds a memory-ready handshake so instruction and data memory accesses may take more than one cycle.

---
 rtl/mips_pkg.sv | 58 +++++
 rtl/mips_mc_ctrl_decode.sv | 62 ++++++
 rtl/mips_mc_control_fsm.sv | 99 +++++++++
 tb/tb_mips_mc_control_fsm.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, mux encodings,
// FSM states and the Moore control vector.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam int unsigned IDLE_CNT_W = 4;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADR   = 4'd3,
      S_MEMREAD  = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWRITE = 4'd6,
      S_EXECUTE  = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_ADDIEX   = 4'd10,
      S_ADDIWB   = 4'd11,
      S_JUMP     = 4'd12
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       branch;
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
   } ctrl_t;

endpackage

// File: rtl/mips_mc_ctrl_decode.sv
// Moore decode: FSM state to datapath control vector, before mem_ready qualification.
module mips_mc_ctrl_decode
   import mips_pkg::*;
(
   input  state_t state,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.ir_write  = 1'b1;
            ctrl.pc_write  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.pc_src    = PCSRC_ALU;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_IMM_SH;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEMREAD: ctrl.iord = 1'b1;
         S_MEMWB: begin
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl.iord      = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         S_EXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_B;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_B;
            ctrl.alu_op    = ALUOP_SUB;
            ctrl.pc_src    = PCSRC_ALUOUT;
            ctrl.branch    = 1'b1;
         end
         S_ADDIWB:  ctrl.reg_write = 1'b1;
         S_JUMP: begin
            ctrl.pc_src   = PCSRC_JUMP;
            ctrl.pc_write = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mips_mc_control_fsm.sv
// Multi-cycle MIPS main control FSM: state register, next-state logic, reset idle
// counter, sticky illegal-opcode flag and mem_ready gating of the fetch writes.
module mips_mc_control_fsm
   import mips_pkg::*;
#(
   parameter int unsigned OP_W              = 6,
   parameter int unsigned RESET_IDLE_CYCLES = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [OP_W-1:0] Op,
   input  logic            Zero,
   input  logic            mem_ready,
   output logic            PCWriteetc,
   output logic            IorD,
   output logic            MemWrite,
   output logic            IRWrite,
   output logic            RegDst,
   output logic            MemtoReg,
   output logic            RegWrite,
   output logic            ALUSrcA,
   output logic [1:0]      ALUSrcB,
   output logic [1:0]      ALUOp,
   output logic [1:0]      PCSrc,
   output logic            illegal_op
);

   state_t                  state;
   state_t                  state_nx;
   logic [IDLE_CNT_W-1:0]   idle_cnt;
   logic                    idle_done;
   logic                    set_illegal;
   logic                    mem_gate;
   ctrl_t                   ctrl;

   assign idle_done = (idle_cnt == IDLE_CNT_W'(RESET_IDLE_CYCLES));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt   <= '0;
         illegal_op <= 1'b0;
      end else begin
         if (state == S_IDLE && !idle_done) idle_cnt <= idle_cnt + IDLE_CNT_W'(1);
         if (set_illegal) illegal_op <= 1'b1;
      end
   end

   always_comb begin
      state_nx    = state;
      set_illegal = 1'b0;
      case (state)
         S_IDLE:     if (idle_done) state_nx = S_FETCH;
         S_FETCH:    if (mem_ready) state_nx = S_DECODE;
         S_DECODE: begin
            if (Op == OP_W'(OP_LW) || Op == OP_W'(OP_SW)) state_nx = S_MEMADR;
            else if (Op == OP_W'(OP_RTYPE))               state_nx = S_EXECUTE;
            else if (Op == OP_W'(OP_BEQ))                 state_nx = S_BRANCH;
            else if (Op == OP_W'(OP_ADDI))                state_nx = S_ADDIEX;
            else if (Op == OP_W'(OP_J))                   state_nx = S_JUMP;
            else begin
               state_nx    = S_FETCH;
               set_illegal = 1'b1;
            end
         end
         S_MEMADR:   state_nx = (Op == OP_W'(OP_LW)) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_ready) state_nx = S_MEMWB;
         S_MEMWRITE: if (mem_ready) state_nx = S_FETCH;
         S_EXECUTE:  state_nx = S_ALUWB;
         S_ADDIEX:   state_nx = S_ADDIWB;
         S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_nx = S_FETCH;
         default:    state_nx = S_FETCH;
      endcase
   end

   mips_mc_ctrl_decode u_decode (
      .state (state),
      .ctrl  (ctrl)
   );

   // Only the fetch-cycle writes wait on memory; JUMP's PC write is unconditional.
   assign mem_gate   = (state != S_FETCH) || mem_ready;
   assign PCWriteetc = (ctrl.pc_write & mem_gate) | (ctrl.branch & Zero);
   assign IRWrite    = ctrl.ir_write & mem_gate;
   assign IorD       = ctrl.iord;
   assign MemWrite   = ctrl.mem_write;
   assign RegDst     = ctrl.reg_dst;
   assign MemtoReg   = ctrl.mem_to_reg;
   assign RegWrite   = ctrl.reg_write;
   assign ALUSrcA    = ctrl.alu_src_a;
   assign ALUSrcB    = ctrl.alu_src_b;
   assign ALUOp      = ctrl.alu_op;
   assign PCSrc      = ctrl.pc_src;

endmodule

// File: tb/tb_mips_mc_control_fsm.sv
// Bench for mips_mc_control_fsm: each instruction is expanded into its expected
// per-cycle control trace from the instruction-level rules, then replayed cycle by cycle.
module tb_mips_mc_control_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] Op;
   logic       Zero;
   logic       mem_ready;
   logic       PCWriteetc, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, ALUOp, PCSrc;
   logic       illegal_op;

   int checks   = 0;
   int failures = 0;
   logic model_ill;

   typedef struct {
      logic        mr;
      logic        z;
      logic [14:0] exp;
      logic        ill;
      string       tag;
   } step_t;

   step_t q[$];

   mips_mc_control_fsm #(.OP_W(6), .RESET_IDLE_CYCLES(1)) dut (
      .clk(clk), .rst(rst), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
      .PCWriteetc(PCWriteetc), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   function automatic logic [14:0] v(input logic pcw, iord, mw, irw, rd, m2r, rw, sa,
                                     input logic [1:0] sb, ao, ps);
      return {pcw, iord, mw, irw, rd, m2r, rw, sa, sb, ao, ps};
   endfunction

   function automatic logic [14:0] observed();
      return {PCWriteetc, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
              ALUSrcB, ALUOp, PCSrc};
   endfunction

   function automatic bit legal(input logic [5:0] op);
      return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
             op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
   endfunction

   task automatic check(input string tag, input logic [14:0] exp, input logic ill);
      logic [14:0] obs;
      obs = observed();
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s ctrl obs=%b exp=%b", tag, obs, exp);
      end
      checks++;
      assert (illegal_op === ill) else begin
         failures++;
         $error("FAIL %s illegal_op obs=%b exp=%b", tag, illegal_op, ill);
      end
   endtask

   task automatic push(input logic mr, input logic z, input logic [14:0] exp, input string tag);
      step_t s;
      s.mr = mr; s.z = z; s.exp = exp; s.ill = model_ill; s.tag = tag;
      q.push_back(s);
   endtask

   // Hold rst for 3 cycles, release, then expect two idle observations before FETCH.
   task automatic reset_seq();
      rst = 1'b1;
      mem_ready = 1'b1;
      model_ill = 1'b0;
      repeat (3) begin
         @(negedge clk);
         Zero = 1'($urandom);
         #1 check("rst", '0, 1'b0);
      end
      @(negedge clk);
      rst = 1'b0;
      #1 check("idle0", '0, 1'b0);
      @(negedge clk);
      Zero = 1'b1;
      #1 check("idle1", '0, 1'b0);
   endtask

   task automatic run_instr(input logic [5:0] op, input int wf, input int wm,
                            input logic zb, input bit abort_wb);
      q.delete();
      for (int i = 0; i < wf; i++) push(1'b0, 1'($urandom), v(0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00), "fetch_wait");
      push(1'b1, 1'($urandom), v(1,0,0,1,0,0,0,0,2'b01,2'b00,2'b00), "fetch");
      push(1'($urandom), 1'($urandom), v(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00), "decode");
      case (op)
         6'b100011: begin
            push(1'($urandom), 1'($urandom), v(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00), "memadr");
            for (int i = 0; i < wm; i++) push(1'b0, 1'($urandom), v(0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00), "memread_wait");
            push(1'b1, 1'($urandom), v(0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00), "memread");
            push(1'($urandom), 1'($urandom), v(0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00), "memwb");
         end
         6'b101011: begin
            push(1'($urandom), 1'($urandom), v(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00), "memadr");
            for (int i = 0; i < wm; i++) push(1'b0, 1'($urandom), v(0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00), "memwrite_wait");
            push(1'b1, 1'($urandom), v(0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00), "memwrite");
         end
         6'b000000: begin
            push(1'($urandom), 1'($urandom), v(0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00), "execute");
            push(1'($urandom), 1'($urandom), v(0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00), "aluwb");
         end
         6'b000100:
            push(1'($urandom), zb, v(zb,0,0,0,0,0,0,1,2'b00,2'b01,2'b01), "branch");
         6'b001000: begin
            push(1'($urandom), 1'($urandom), v(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00), "addiex");
            push(1'($urandom), 1'($urandom), v(0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00), "addiwb");
         end
         6'b000010:
            push(1'($urandom), 1'($urandom), v(1,0,0,0,0,0,0,0,2'b00,2'b00,2'b10), "jump");
         default: model_ill = 1'b1;
      endcase
      foreach (q[i]) begin
         @(negedge clk);
         mem_ready = q[i].mr;
         Zero      = q[i].z;
         Op        = op;
         #1 check(q[i].tag, q[i].exp, q[i].ill);
         if (abort_wb && q[i].tag == "memwb") begin
            #2 rst = 1'b1;
            #1 check("rst_in_memwb", '0, 1'b0);
            reset_seq();
            break;
         end
      end
   endtask

   initial begin
      logic [5:0] op;
      logic [5:0] ops[6];
      ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000;
      ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b000010;
      rst = 1'b1;
      Op = '0;
      Zero = 1'b0;
      mem_ready = 1'b1;
      model_ill = 1'b0;

      reset_seq();
      run_instr(6'b100011, 0, 0, 1'b0, 1'b0);
      run_instr(6'b101011, 0, 3, 1'b0, 1'b0);
      run_instr(6'b000100, 0, 0, 1'b1, 1'b0);
      run_instr(6'b000100, 0, 0, 1'b0, 1'b0);
      run_instr(6'b111111, 0, 0, 1'b0, 1'b0);
      run_instr(6'b000000, 0, 0, 1'b0, 1'b0);
      run_instr(6'b001000, 2, 0, 1'b0, 1'b0);
      run_instr(6'b000010, 1, 0, 1'b0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 6) == 6) begin
            op = 6'($urandom);
            while (legal(op)) op = 6'($urandom);
         end else begin
            op = ops[$urandom_range(0, 5)];
         end
         run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom), 1'b0);
      end

      reset_seq();
      run_instr(6'b100011, 1, 2, 1'b0, 1'b1);
      run_instr(6'b000010, 0, 0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
